// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Signal bundle for the display driver: the inputs from the chronometer side
// and the anode/segment outputs toward the display.
//   master : drives value/dp_en/blank_lz/enable, observes display outputs
//   slave  : the driver's view
interface seg7_scan_driver_if;
    logic [15:0] value;
    logic [3:0]  dp_en;
    logic        blank_lz;
    logic        enable;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    modport master (
        output value, dp_en, blank_lz, enable,
        input  an, seg, dp, frame_done
    );

    modport slave (
        input  value, dp_en, blank_lz, enable,
        output an, seg, dp, frame_done
    );
endinterface

// File: rtl/seg7_decoder.sv
// Combinational hex nibble to 7-segment pattern decode.
//   nibble : 4-bit value 0..15
//   seg    : active-low segments {g,f,e,d,c,b,a}; 10..15 show A,b,C,d,E,F
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_F;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            default: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment driver.
// Each digit owns a slot of DIGIT_CYCLES clocks; the first GUARD clocks of a
// slot keep all anodes off to avoid ghosting. Display data is taken from
// shadow registers loaded once per frame so a digit never changes mid-frame.
//   clk, rst    : clock, synchronous active-high reset
//   value       : four nibbles, [3:0] is the rightmost digit
//   dp_en       : decimal point enable per digit
//   blank_lz    : leading-zero blanking enable
//   enable      : display enable; scanning holds while low
//   an/seg/dp   : registered active-low anode, segment and decimal point
//   frame_done  : single-cycle pulse on the cycle the shadows are loaded
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int CLK_FPGA   = 100000000,
    parameter int REFRESH_HZ = 1000,
    parameter int GUARD      = 16
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic [3:0]  dp_en,
    input  logic        blank_lz,
    input  logic        enable,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int DIGIT_CYCLES = CLK_FPGA / (4 * REFRESH_HZ);
    localparam int CW = $clog2(DIGIT_CYCLES + 1);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_GUARD = CW'(GUARD);

    if (DIGIT_CYCLES < GUARD + 2) begin : g_param_check
        $error("seg7_scan_driver: DIGIT_CYCLES must be at least GUARD+2");
    end

    logic [CW-1:0] slot_cnt;
    logic [1:0]    digit_idx;
    logic [15:0]   value_s;
    logic [3:0]    dp_en_s;
    logic          blank_lz_s;

    logic          slot_last;
    logic          capture;
    logic [3:0]    nibble;
    logic          lead_zero;
    logic          blank;
    logic [6:0]    seg_dec;

    assign slot_last  = (slot_cnt == SLOT_LAST);
    assign capture    = enable && slot_last && (digit_idx == 2'd3);
    // Reset wins over a capture landing on the same edge.
    assign frame_done = capture && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt   <= '0;
            digit_idx  <= 2'd0;
            value_s    <= 16'h0000;
            dp_en_s    <= 4'h0;
            blank_lz_s <= 1'b0;
        end else if (enable) begin
            if (slot_last) begin
                slot_cnt  <= '0;
                digit_idx <= digit_idx + 2'd1;
            end else begin
                slot_cnt  <= slot_cnt + 1'b1;
            end
            if (capture) begin
                value_s    <= value;
                dp_en_s    <= dp_en;
                blank_lz_s <= blank_lz;
            end
        end
    end

    // A digit is a leading zero when it and every higher nibble are zero;
    // the rightmost digit is always shown.
    always_comb begin
        nibble    = value_s[3:0];
        lead_zero = 1'b0;
        case (digit_idx)
            2'd3: begin
                nibble    = value_s[15:12];
                lead_zero = (value_s[15:12] == 4'h0);
            end
            2'd2: begin
                nibble    = value_s[11:8];
                lead_zero = (value_s[15:8] == 8'h00);
            end
            2'd1: begin
                nibble    = value_s[7:4];
                lead_zero = (value_s[15:4] == 12'h000);
            end
            default: begin
                nibble    = value_s[3:0];
                lead_zero = 1'b0;
            end
        endcase
    end

    assign blank = blank_lz_s && lead_zero;

    seg7_decoder u_decoder (
        .nibble (nibble),
        .seg    (seg_dec)
    );

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= (slot_cnt < SLOT_GUARD) ? AN_OFF : ~(4'b0001 << digit_idx);
            seg <= blank ? SEG_BLANK : seg_dec;
            dp  <= ~(dp_en_s[digit_idx] & ~blank);
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with a 10-cycle digit slot and 2-cycle guard.
// The reference model tracks position in the 40-cycle frame as a plain
// integer and derives digit/slot/blanking from it arithmetically.
module tb_seg7_scan_driver;

    localparam int DC    = 10;
    localparam int GD    = 2;
    localparam int FRAME = 4 * DC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg7_scan_driver_if bus ();

    seg7_scan_driver #(
        .CLK_FPGA   (4000),
        .REFRESH_HZ (100),
        .GUARD      (GD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (bus.value),
        .dp_en      (bus.dp_en),
        .blank_lz   (bus.blank_lz),
        .enable     (bus.enable),
        .an         (bus.an),
        .seg        (bus.seg),
        .dp         (bus.dp),
        .frame_done (bus.frame_done)
    );

    int total = 0;
    int bad   = 0;

    int          mt    = 0;
    logic [15:0] sv    = 16'h0;
    logic [3:0]  sdp   = 4'h0;
    logic        sblz  = 1'b0;
    logic        armed = 1'b0;
    logic        fd_obs;

    logic [6:0] pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: frame_done checked before the edge, registered outputs after.
    task automatic tick();
        logic [3:0] ean;
        logic [6:0] eseg;
        logic       edp;
        logic       efd;
        logic       blk;
        int         idx;
        int         slot;
        #1;
        fd_obs = bus.frame_done;
        idx  = mt / DC;
        slot = mt % DC;
        efd  = !rst && bus.enable && (mt == FRAME - 1);
        if (armed) check("frame_done", {15'b0, bus.frame_done}, {15'b0, efd});
        @(posedge clk);
        if (rst) begin
            ean = 4'hF; eseg = 7'h7F; edp = 1'b1;
            mt = 0; sv = 16'h0; sdp = 4'h0; sblz = 1'b0;
            armed = 1'b1;
        end else if (!bus.enable) begin
            ean = 4'hF; eseg = 7'h7F; edp = 1'b1;
        end else begin
            blk  = sblz && (idx > 0) && ((sv >> (4 * idx)) == 16'h0);
            ean  = (slot < GD) ? 4'hF : (4'hF ^ (4'h1 << idx));
            eseg = blk ? 7'h7F : pat[(sv >> (4 * idx)) & 16'hF];
            edp  = (!blk && sdp[idx]) ? 1'b0 : 1'b1;
            if (mt == FRAME - 1) begin
                sv = bus.value; sdp = bus.dp_en; sblz = bus.blank_lz;
            end
            mt = (mt + 1) % FRAME;
        end
        #1;
        if (armed) begin
            check("an",  {12'b0, bus.an},  {12'b0, ean});
            check("seg", {9'b0, bus.seg},  {9'b0, eseg});
            check("dp",  {15'b0, bus.dp},  {15'b0, edp});
        end
    endtask

    task automatic run_to(input int p);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (mt == p) begin hit = 1'b1; break; end
        end
        check("run_to_reached", {15'b0, hit}, 16'h1);
    endtask

    task automatic wait_capture();
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < FRAME + 5; i++) begin
            tick();
            if (fd_obs) begin hit = 1'b1; break; end
        end
        check("capture_seen", {15'b0, hit}, 16'h1);
    endtask

    task automatic first_fd_after(input string tag);
        int n;
        n = -1;
        for (int i = 0; i < FRAME + 20; i++) begin
            tick();
            if (fd_obs) begin n = i; break; end
        end
        check(tag, n[15:0], 16'd39);
    endtask

    initial begin
        bus.value    = 16'h0000;
        bus.dp_en    = 4'h0;
        bus.blank_lz = 1'b0;
        bus.enable   = 1'b1;
        rst = 1'b1;
        tick();
        check("reset_an",  {12'b0, bus.an},  16'h000F);
        check("reset_seg", {9'b0, bus.seg},  16'h007F);
        check("reset_dp",  {15'b0, bus.dp},  16'h0001);
        tick();
        rst = 1'b0;

        // First frame after reset shows zeros; capture lands on cycle 39.
        first_fd_after("first_frame_done");

        // 1234 with a decimal point on digit 2.
        bus.value = 16'h1234; bus.dp_en = 4'b0100; bus.blank_lz = 1'b0;
        wait_capture();
        run_to(6);
        check("d0_an",  {12'b0, bus.an},  16'h000E);
        check("d0_seg", {9'b0, bus.seg},  16'h0019);
        run_to(26);
        check("d2_an",  {12'b0, bus.an},  16'h000B);
        check("d2_seg", {9'b0, bus.seg},  16'h0024);
        check("d2_dp",  {15'b0, bus.dp},  16'h0000);

        // Leading-zero blanking.
        bus.value = 16'h0050; bus.dp_en = 4'hF; bus.blank_lz = 1'b1;
        wait_capture();
        run_to(6);
        check("lz_d0", {9'b0, bus.seg}, 16'h0040);
        run_to(16);
        check("lz_d1", {9'b0, bus.seg}, 16'h0012);
        run_to(26);
        check("lz_d2", {9'b0, bus.seg}, 16'h007F);
        check("lz_d2_dp", {15'b0, bus.dp}, 16'h0001);
        run_to(36);
        check("lz_d3", {9'b0, bus.seg}, 16'h007F);
        bus.value = 16'h0000; bus.dp_en = 4'h0;
        wait_capture();
        wait_capture();

        // Mid-frame value change is deferred to the next capture.
        bus.value = 16'h1111; bus.blank_lz = 1'b0;
        wait_capture();
        run_to(21);
        bus.value = 16'h8888;
        run_to(36);
        check("tear_old", {9'b0, bus.seg}, 16'h0079);
        wait_capture();
        run_to(6);
        check("tear_new", {9'b0, bus.seg}, 16'h0000);

        // Enable low for 25 cycles mid-slot.
        run_to(14);
        bus.enable = 1'b0;
        for (int i = 0; i < 25; i++) tick();
        check("hold_an", {12'b0, bus.an}, 16'h000F);
        bus.enable = 1'b1;
        run_to(20);
        check("resume_an", {12'b0, bus.an}, 16'h000D);

        // Reset during digit 2 abandons the frame.
        run_to(25);
        rst = 1'b1;
        tick();
        check("midrst_an",  {12'b0, bus.an},  16'h000F);
        check("midrst_seg", {9'b0, bus.seg},  16'h007F);
        rst = 1'b0;
        first_fd_after("frame_done_after_rst");

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 4))
                0: bus.value = 16'h0000;
                1: bus.value = 16'(($urandom) & 32'h000F);
                2: bus.value = 16'(($urandom) & 32'h00FF);
                3: bus.value = 16'(($urandom) & 32'h0FFF);
                default: bus.value = 16'($urandom);
            endcase
            bus.dp_en    = 4'($urandom);
            bus.blank_lz = 1'($urandom);
            bus.enable   = ($urandom_range(0, 15) != 0);
            rst          = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        bus.enable = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
